hazard_unit: RTL and testbench
==============================

# hazard_unit

- Pipeline hazard controller for the 5-stage RISC-V core.
- Produces the `forward_a`/`forward_b` selects consumed by the execute stage.
- Generates stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sequences two multi-cycle conditions:
  - data-memory wait (freeze the whole pipe);
  - serializing-instruction drain (hold decode until older instructions retire).

## Interface
Parameters:
- REG_WIDTH, 5, register index width
- DRAIN_CYCLES, 3, bubble cycles inserted by a drain (≥1)
- CNT_WIDTH, 32, performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- rs1_d, rs2_d  in  REG_WIDTH  source registers in decode
- rs1_e, rs2_e  in  REG_WIDTH  source registers in execute (rd1_in/rd2_in)
- rd_e, rd_m, rd_w  in  REG_WIDTH  destination registers in EX/MEM/WB
- reg_write_m, reg_write_w  in  1  write enables in MEM/WB
- result_src_e  in  2  execute result select; 2'b01 = load
- pc_src_e  in  1  branch/jump taken in execute
- drain_d  in  1  decode holds a serializing instruction (fence/CSR/ecall)
- mem_busy  in  1  data memory not ready; level signal
- forward_a, forward_b  out  2  00 = ID/EX data, 10 = mem_out, 01 = wb_out
- stall_f, stall_d, stall_e, stall_m  out  1  hold PC / IF-ID / ID-EX / EX-MEM
- flush_d, flush_e, flush_w  out  1  bubble into IF-ID / ID-EX / MEM-WB
- drain_done  out  1  one-cycle pulse in the last drain cycle
- stall_cycles, flush_events  out  CNT_WIDTH  performance counters

## Operation
Forwarding is combinational in every state:
- forward_a = 10 when rs1_e≠0, rs1_e==rd_m and reg_write_m.
- Otherwise forward_a = 01 when rs1_e≠0, rs1_e==rd_w and reg_write_w.
- Otherwise forward_a = 00.
- MEM takes priority over WB. forward_b follows the same rule on rs2_e.

Control signals are combinational from the state and the inputs. FSM states:
- RUN:
  - Priority: mem_busy > pc_src_e > load-use > drain_d.
  - mem_busy: stall_f, stall_d, stall_e, stall_m and flush_w = 1; next state MEM_WAIT; resume = RUN.
  - pc_src_e: flush_d = flush_e = 1; stall_f = 0.
  - Load-use, i.e. result_src_e==01, rd_e≠0 and (rd_e==rs1_d or rd_e==rs2_d): stall_f = stall_d = flush_e = 1.
  - drain_d: stall_f = stall_d = flush_e = 1; cnt ← DRAIN_CYCLES-1; next state DRAIN.
- DRAIN:
  - Outputs: stall_f = stall_d = flush_e = 1.
  - cnt decrements each cycle. drain_done = 1 when cnt==0; next state RUN.
  - pc_src_e (older branch): abort the drain; flush_d = flush_e = 1; next state RUN; no drain_done.
  - mem_busy has priority over both: freeze as in RUN; next state MEM_WAIT; resume = DRAIN; cnt held.
- MEM_WAIT:
  - Full freeze (stall_f..stall_m = 1, flush_w = 1) while mem_busy = 1.
  - No flush_d/flush_e while frozen. A pending pc_src_e stays asserted by the frozen execute stage and is acted on after exit.
  - On mem_busy = 0: outputs are evaluated as in the resume state this same cycle; next state = resume.
- Reset:
  - state = RUN, cnt = 0, resume = RUN, counters = 0.
  - During reset all stall/flush outputs = 0, drain_done = 0; forward_* still combinational.
  - Reset mid-drain or mid-wait abandons the operation.

## Timing
- Forwarding and stall/flush: zero latency, same cycle as the inputs.
- Load-use: exactly one bubble per qualifying load.
- Drain:
  - drain_d seen in RUN at cycle T; stall_f/stall_d asserted T..T+DRAIN_CYCLES.
  - drain_done at T+DRAIN_CYCLES; decode advances at T+DRAIN_CYCLES+1.
  - mem_busy cycles extend the drain one-for-one.
- Redirect: flushes asserted in the cycle pc_src_e = 1 and not frozen.
- Counters update on the clock edge and are visible the next cycle. They wrap at 2^CNT_WIDTH.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments in each non-reset cycle with stall_d = 1.
  - flush_events increments in each cycle with flush_d or flush_e = 1 caused by pc_src_e.
- HAZARD_PERF_CNT_EN undefined: no counter registers are built; stall_cycles and flush_events are tied to 0.

## Test plan
- Forwarding:
  - rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 → forward_a=10.
  - rd_m=0 → forward_a=01.
  - rs1_e=0 → forward_a=00.
- Load-use: result_src_e=01, rd_e=7, rs2_d=7 → stall_f=stall_d=flush_e=1 for one cycle; forward_b=10 the following cycle once the load is in MEM.
- Redirect with load-use: pc_src_e=1 and a load-use in the same cycle → flush_d=flush_e=1, stall_f=0, stall_d=0.
- Drain (DRAIN_CYCLES=3): drain_d at cycle 10 → stall_d=1 for cycles 10-13, drain_done=1 only at cycle 13. With mem_busy during cycle 11 → drain_done moves to cycle 14.
- Memory wait:
  - mem_busy for 4 cycles during RUN → all stalls and flush_w=1 for 4 cycles, then release.
  - pc_src_e held throughout → flush_d/flush_e assert only in the first non-busy cycle.
- Reset and counters:
  - rst during DRAIN → next cycle RUN, outputs 0, no drain_done.
  - With HAZARD_PERF_CNT_EN, after 2 load-use stalls + 1 redirect → stall_cycles=2, flush_events=1; without the macro both read 0.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding, stall/flush control and drain/memory-wait sequencing; HAZARD_PERF_CNT_EN adds perf counters
module hazard_unit #(
    parameter int REG_WIDTH    = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] rs1_d,
    input  logic [REG_WIDTH-1:0] rs2_d,
    input  logic [REG_WIDTH-1:0] rs1_e,
    input  logic [REG_WIDTH-1:0] rs2_e,
    input  logic [REG_WIDTH-1:0] rd_e,
    input  logic [REG_WIDTH-1:0] rd_m,
    input  logic [REG_WIDTH-1:0] rd_w,
    input  logic                 reg_write_m,
    input  logic                 reg_write_w,
    input  logic [1:0]           result_src_e,
    input  logic                 pc_src_e,
    input  logic                 drain_d,
    input  logic                 mem_busy,
    output logic [1:0]           forward_a,
    output logic [1:0]           forward_b,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 stall_m,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 flush_w,
    output logic                 drain_done,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events
);
    localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, MEM_WAIT} state_t;

    state_t        r_state, r_resume, w_next, w_mode, w_resume_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          w_load_use;

    assign forward_a = (rs1_e != '0 && rs1_e == rd_m && reg_write_m) ? 2'b10 :
                       (rs1_e != '0 && rs1_e == rd_w && reg_write_w) ? 2'b01 : 2'b00;
    assign forward_b = (rs2_e != '0 && rs2_e == rd_m && reg_write_m) ? 2'b10 :
                       (rs2_e != '0 && rs2_e == rd_w && reg_write_w) ? 2'b01 : 2'b00;

    assign w_load_use = result_src_e == 2'b01 && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
    // leaving a memory wait behaves exactly like the state it interrupted
    assign w_mode     = (r_state == MEM_WAIT) ? r_resume : r_state;

    // state, resume point and drain countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_resume <= RUN;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_next;
            r_resume <= w_resume_next;
            r_cnt    <= w_cnt_next;
        end
    end

    // next state and stall/flush controls; all quiet while in reset
    always_comb begin
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        stall_e       = 1'b0;
        stall_m       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        flush_w       = 1'b0;
        drain_done    = 1'b0;
        w_next        = w_mode;
        w_resume_next = r_resume;
        w_cnt_next    = r_cnt;
        if (!rst) begin
            if (mem_busy) begin
                {stall_f, stall_d, stall_e, stall_m, flush_w} = '1;
                w_next        = MEM_WAIT;
                w_resume_next = w_mode;
            end else if (w_mode == RUN) begin
                if (pc_src_e) begin
                    {flush_d, flush_e} = '1;
                end else if (w_load_use || drain_d) begin
                    {stall_f, stall_d, flush_e} = '1;
                    if (!w_load_use) begin
                        w_cnt_next = CW'(DRAIN_CYCLES - 1);
                        w_next     = DRAIN;
                    end
                end
            end else if (pc_src_e) begin
                {flush_d, flush_e} = '1;
                w_next = RUN;
            end else begin
                {stall_f, stall_d, flush_e} = '1;
                w_cnt_next = (r_cnt == '0) ? r_cnt : r_cnt - CW'(1);
                drain_done = r_cnt == '0;
                w_next     = (r_cnt == '0) ? RUN : DRAIN;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cycles, r_flush_events;

    // flush_d is raised only by a redirect, so it marks redirect flush events
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (stall_d) r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            if (flush_d) r_flush_events <= r_flush_events + CNT_WIDTH'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table-driven and sequence checks for hazard_unit
module tb_hazard_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        reg_write_m, reg_write_w, pc_src_e, drain_d, mem_busy;
    logic [1:0]  result_src_e, forward_a, forward_b;
    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, drain_done;
    logic [31:0] stall_cycles, flush_events;
    logic [6:0]  ctl;
    int          pass = 0;
    int          total = 0;

`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif
    localparam logic [6:0] A = 7'b1100010;
    localparam logic [6:0] F = 7'b1111001;
    localparam logic [6:0] R = 7'b0000110;
    localparam logic [6:0] Z = 7'b0000000;

    typedef struct {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic       rwm, rww;
        logic [1:0] rse;
        logic       pc;
        logic [1:0] fa, fb;
        logic [6:0] ctl;
    } vec_t;

    vec_t v[13];

    hazard_unit dut (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .result_src_e(result_src_e), .pc_src_e(pc_src_e), .drain_d(drain_d), .mem_busy(mem_busy),
        .forward_a(forward_a), .forward_b(forward_b), .stall_f(stall_f), .stall_d(stall_d),
        .stall_e(stall_e), .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .drain_done(drain_done), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else pass++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {reg_write_m, reg_write_w, pc_src_e, drain_d, mem_busy} = '0;
        result_src_e = 2'b00;
    endtask

    task automatic seq(input string nm, input int n, input logic [7:0] dr, input logic [7:0] bz,
                       input logic [7:0] pc, input logic [7:0] rs, input logic [55:0] ectl,
                       input logic [7:0] edn);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            drain_d  = dr[i];
            mem_busy = bz[i];
            pc_src_e = pc[i];
            rst      = rs[i];
            @(negedge clk);
            chk($sformatf("%s_ctl%0d", nm, i), 32'(ctl), 32'(ectl[i*7 +: 7]));
            chk($sformatf("%s_done%0d", nm, i), 32'(drain_done), 32'(edn[i]));
        end
        next_cycle();
        clear();
        rst = 1'b0;
    endtask

    initial begin
        v[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 2'd0, 1'b0, 2'b10, 2'b00, Z};
        v[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 2'd0, 1'b0, 2'b01, 2'b00, Z};
        v[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'd0, 1'b0, 2'b00, 2'b00, Z};
        v[3]  = '{5'd0, 5'd0, 5'd1, 5'd3, 5'd0, 5'd3, 5'd3, 1'b0, 1'b1, 2'd0, 1'b0, 2'b00, 2'b01, Z};
        v[4]  = '{5'd0, 5'd0, 5'd9, 5'd4, 5'd0, 5'd4, 5'd9, 1'b1, 1'b1, 2'd0, 1'b0, 2'b01, 2'b10, Z};
        v[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'd1, 1'b0, 2'b00, 2'b00, A};
        v[6]  = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 2'b10, Z};
        v[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd1, 1'b0, 2'b00, 2'b00, Z};
        v[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 2'b00, Z};
        v[9]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'd1, 1'b1, 2'b00, 2'b00, R};
        v[10] = '{5'd8, 5'd0, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 2'd1, 1'b0, 2'b00, 2'b00, A};
        v[11] = '{5'd8, 5'd0, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 2'd3, 1'b0, 2'b00, 2'b00, Z};
        v[12] = '{5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd6, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 2'b00, Z};

        clear();
        rst = 1'b1;
        rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1;
        result_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7; mem_busy = 1'b1; drain_d = 1'b1;
        @(negedge clk);
        chk("rst_fwd_a", 32'(forward_a), 32'd2);
        chk("rst_ctl", 32'(ctl), 32'd0);
        chk("rst_done", 32'(drain_done), 32'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        clear();
        @(negedge clk);
        chk("rst_stall_cnt", stall_cycles, 32'd0);
        chk("rst_flush_cnt", flush_events, 32'd0);

        foreach (v[k]) begin
            next_cycle();
            {rs1_d, rs2_d, rs1_e, rs2_e} = {v[k].rs1_d, v[k].rs2_d, v[k].rs1_e, v[k].rs2_e};
            {rd_e, rd_m, rd_w} = {v[k].rd_e, v[k].rd_m, v[k].rd_w};
            {reg_write_m, reg_write_w, result_src_e, pc_src_e} = {v[k].rwm, v[k].rww, v[k].rse, v[k].pc};
            @(negedge clk);
            chk($sformatf("vec%0d_fwd_a", k), 32'(forward_a), 32'(v[k].fa));
            chk($sformatf("vec%0d_fwd_b", k), 32'(forward_b), 32'(v[k].fb));
            chk($sformatf("vec%0d_ctl", k), 32'(ctl), 32'(v[k].ctl));
            chk($sformatf("vec%0d_done", k), 32'(drain_done), 32'd0);
        end
        next_cycle();
        clear();
        chk("stall_cnt", stall_cycles, 32'(2 * PERF));
        chk("flush_cnt", flush_events, 32'(PERF));

        seq("drain", 5, 8'b1, 8'b0, 8'b0, 8'b0, {Z, A, A, A, A}, 8'b01000);
        seq("drain_busy", 6, 8'b1, 8'b10, 8'b0, 8'b0, {Z, A, A, A, F, A}, 8'b010000);
        seq("memwait", 6, 8'b0, 8'b001111, 8'b011111, 8'b0, {Z, R, F, F, F, F}, 8'b0);
        seq("drain_abort", 3, 8'b1, 8'b0, 8'b010, 8'b0, {Z, R, A}, 8'b0);
        seq("drain_rst", 4, 8'b1, 8'b0, 8'b0, 8'b0010, {Z, Z, Z, A}, 8'b0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
